// File: rtl/core_seq_if.sv
// Connection bundle between the sequencer and the memory, register-file and ALU
// blocks it drives; the sequencer side is the master.
interface core_seq_if;
    logic [31:0] mem_addr;
    logic        mem_w;
    logic [31:0] mem_w_v;
    logic [31:0] mem_r_v;

    logic        rf_w;
    logic [4:0]  rf_dst;
    logic [4:0]  rf_src1;
    logic [4:0]  rf_src2;
    logic [31:0] rf_w_v;
    logic [31:0] rf_src1_v;
    logic [31:0] rf_src2_v;

    logic        alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_c;
    logic [31:0] alu_out;

    modport master (
        output mem_addr, mem_w, mem_w_v,
        input  mem_r_v,
        output rf_w, rf_dst, rf_src1, rf_src2, rf_w_v,
        input  rf_src1_v, rf_src2_v,
        output alu_op, alu_a, alu_b, alu_c,
        input  alu_out
    );

    modport slave (
        input  mem_addr, mem_w, mem_w_v,
        output mem_r_v,
        input  rf_w, rf_dst, rf_src1, rf_src2, rf_w_v,
        output rf_src1_v, rf_src2_v,
        input  alu_op, alu_a, alu_b, alu_c,
        output alu_out
    );
endinterface

// File: rtl/core_seq.sv
// Multicycle fetch/decode/execute sequencer: owns PC, IR, operand/result latches
// and the retire counter, and steers the external memory, register file and ALU.
module core_seq #(
    parameter logic [31:0] PC_RESET  = 32'd0,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    core_seq_if.master        bus,
    output logic [31:0]       pc,
    output logic              halted,
    output logic [31:0]       retired
);
    localparam logic [31:0] DEPTH = MEM_DEPTH;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_MEMW,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] res;
    logic        rf_w_q;
    logic        mem_w_q;

    logic        f_br;
    logic        f_mem;
    logic        f_we;
    logic        f_op;
    logic [4:0]  f_dst;
    logic [31:0] imm_ext;
    logic [31:0] pc_inc;
    logic [32:0] br_sum;
    logic [31:0] pc_br;
    logic [31:0] res_addr;

    assign f_br    = ir[24];
    assign f_mem   = ir[23];
    assign f_we    = ir[22];
    assign f_op    = ir[21];
    assign f_dst   = ir[14:10];
    assign imm_ext = {{27{ir[19]}}, ir[19:15]};

    // PC arithmetic stays inside [0, MEM_DEPTH); a branch moves at most 16 words,
    // so a single correction in either direction is enough.
    assign pc_inc   = (pc == DEPTH - 32'd1) ? 32'd0 : pc + 32'd1;
    assign br_sum   = {1'b0, pc} + {imm_ext[31], imm_ext};
    assign pc_br    = br_sum[32] ? br_sum[31:0] + DEPTH :
                      (br_sum[31:0] >= DEPTH) ? br_sum[31:0] - DEPTH : br_sum[31:0];
    assign res_addr = res % DEPTH;

    assign bus.rf_dst  = f_dst;
    assign bus.rf_src1 = ir[9:5];
    assign bus.rf_src2 = ir[4:0];
    assign bus.rf_w_v  = f_mem ? bus.mem_r_v : res;
    assign bus.mem_w_v = opb;
    assign bus.alu_op  = f_mem | f_op;
    assign bus.alu_a   = opa;
    assign bus.alu_b   = f_mem ? 32'd0 : opb;
    assign bus.alu_c   = imm_ext;
    assign bus.rf_w    = rf_w_q;
    assign bus.mem_w   = mem_w_q;
    assign halted      = (state == S_HALT);

    always_comb begin
        state_next   = state;
        bus.mem_addr = pc;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = (ir == 32'd0) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (f_br) begin
                    state_next = S_FETCH;
                end else if (f_we) begin
                    state_next = S_WB;
                end else if (f_mem) begin
                    state_next = S_MEMW;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_WB: begin
                if (f_mem) begin
                    bus.mem_addr = res_addr;
                end
                state_next = S_FETCH;
            end
            S_MEMW: begin
                bus.mem_addr = res_addr;
                state_next   = S_FETCH;
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Write strobes are registered one cycle ahead so they are clean for the
    // register file's negedge sample during WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            pc      <= PC_RESET;
            ir      <= 32'd0;
            opa     <= 32'd0;
            opb     <= 32'd0;
            res     <= 32'd0;
            retired <= 32'd0;
            rf_w_q  <= 1'b0;
            mem_w_q <= 1'b0;
        end else begin
            state   <= state_next;
            rf_w_q  <= (state_next == S_WB) && (f_dst != 5'd0);
            mem_w_q <= (state_next == S_MEMW);
            case (state)
                S_FETCH: ir <= bus.mem_r_v;
                S_DECODE: begin
                    opa <= bus.rf_src1_v;
                    opb <= bus.rf_src2_v;
                end
                S_EXEC: begin
                    res <= bus.alu_out;
                    if (f_br) begin
                        pc      <= pc_br;
                        retired <= retired + 32'd1;
                    end else if (!f_we && !f_mem) begin
                        pc      <= pc_inc;
                        retired <= retired + 32'd1;
                    end
                end
                S_WB, S_MEMW: begin
                    pc      <= pc_inc;
                    retired <= retired + 32'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
